// File: rtl/pipe_decode_ctrl.sv
// RV32I (+ optional M) decode stage feeding the ID/EX control register, with
// valid/ready handshake, load-use bubbles, EX-driven flush and a divide stall.
module pipe_decode_ctrl #(
  parameter int unsigned ENABLE_M    = 0,
  parameter int unsigned MDIV_CYCLES = 8,
  parameter int unsigned ALUOP_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               regWR,
  output logic               memWR,
  output logic               aluS1,
  output logic               aluS2,
  output logic               doJump,
  output logic               doBranch,
  output logic [1:0]         wbCtrl,
  output logic [2:0]         branchCtrl,
  output logic [2:0]         memCtrl,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] WB_DEF  = 2'b11;
  localparam logic [2:0] BRC_DEF = 3'b011;
  localparam logic [4:0] ALU_DEF = 5'b01001;

  typedef enum logic {IDLE, MDIV_WAIT} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [3:0] base;
  logic       d_regwr, d_memwr, d_alus1, d_alus2, d_jump, d_branch;
  logic       d_illegal, d_div, uses_rs1, uses_rs2;
  logic [1:0] d_wb;
  logic [2:0] d_brc, d_mem;
  logic [4:0] d_aluop;
  logic       advance, hazard, accept;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    if (f3 == 3'b000 || f3 == 3'b101) base = {f7[5], f3};
    else if (f7 == 7'b0000000)        base = {1'b0, f3};
    else                              base = 4'b1001;
  end

  // Illegal encodings only raise the flag; every control stays at its default.
  always_comb begin
    d_regwr   = 1'b0;
    d_memwr   = 1'b0;
    d_alus1   = 1'b0;
    d_alus2   = 1'b0;
    d_jump    = 1'b0;
    d_branch  = 1'b0;
    d_wb      = WB_DEF;
    d_brc     = BRC_DEF;
    d_mem     = 3'b000;
    d_aluop   = ALU_DEF;
    d_illegal = 1'b0;
    d_div     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opc)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (f7 == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            d_regwr = 1'b1;
            d_wb    = 2'b00;
            d_alus2 = 1'b1;
            d_aluop = {2'b11, f3};
            d_div   = f3[2];
          end else begin
            d_illegal = 1'b1;
          end
        end else if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          d_regwr = 1'b1;
          d_wb    = 2'b00;
          d_alus2 = 1'b1;
          d_aluop = {1'b0, base};
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_I: begin
        uses_rs1 = 1'b1;
        d_regwr  = 1'b1;
        d_wb     = 2'b00;
        d_aluop  = (f3 == 3'b000) ? 5'b00000 : {1'b0, base};
      end
      OP_LOAD: begin
        uses_rs1 = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
          d_illegal = 1'b1;
        end else begin
          d_regwr = 1'b1;
          d_wb    = 2'b01;
          d_aluop = '0;
          case (f3)
            3'b000:  d_mem = 3'b000;
            3'b001:  d_mem = 3'b001;
            3'b010:  d_mem = 3'b010;
            3'b100:  d_mem = 3'b011;
            default: d_mem = 3'b100;
          endcase
        end
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (f3[2] || f3 == 3'b011) begin
          d_illegal = 1'b1;
        end else begin
          d_memwr = 1'b1;
          d_aluop = '0;
          case (f3)
            3'b000:  d_mem = 3'b101;
            3'b001:  d_mem = 3'b110;
            default: d_mem = 3'b111;
          endcase
        end
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        d_branch = 1'b1;
        d_brc    = f3;
        d_alus1  = 1'b1;
        d_aluop  = '0;
      end
      OP_LUI: begin
        d_regwr = 1'b1;
        d_wb    = 2'b00;
        d_aluop = '0;
      end
      OP_AUIPC: begin
        d_regwr = 1'b1;
        d_wb    = 2'b00;
        d_alus1 = 1'b1;
        d_aluop = '0;
      end
      OP_JAL: begin
        d_regwr = 1'b1;
        d_wb    = 2'b10;
        d_jump  = 1'b1;
        d_alus1 = 1'b1;
        d_aluop = '0;
      end
      OP_JALR: begin
        uses_rs1 = 1'b1;
        d_regwr  = 1'b1;
        d_wb     = 2'b10;
        d_jump   = 1'b1;
        d_aluop  = '0;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign advance = !out_valid || out_ready;
  assign hazard  = out_valid && (wbCtrl == 2'b01) && (rd != '0) &&
                   ((uses_rs1 && rd == instr[19:15]) || (uses_rs2 && rd == instr[24:20]));
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept && d_div) begin
          state_nx = MDIV_WAIT;
          cnt_nx   = 8'(MDIV_CYCLES);
        end
      end
      MDIV_WAIT: begin
        if (cnt <= 8'd1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    in_ready = advance && !hazard && (state == IDLE) && !flush;
  end

  // A bubble is simply the reset control word; stalls (!advance) hold everything.
  always_ff @(posedge clk) begin
    if (rst || flush || (advance && !accept)) begin
      out_valid  <= 1'b0;
      regWR      <= 1'b0;
      memWR      <= 1'b0;
      aluS1      <= 1'b0;
      aluS2      <= 1'b0;
      doJump     <= 1'b0;
      doBranch   <= 1'b0;
      wbCtrl     <= WB_DEF;
      branchCtrl <= BRC_DEF;
      memCtrl    <= 3'b000;
      aluOp      <= ALUOP_W'(ALU_DEF);
      rd         <= '0;
      rs1        <= '0;
      rs2        <= '0;
      illegal    <= 1'b0;
    end else if (advance) begin
      out_valid  <= 1'b1;
      regWR      <= d_regwr;
      memWR      <= d_memwr;
      aluS1      <= d_alus1;
      aluS2      <= d_alus2;
      doJump     <= d_jump;
      doBranch   <= d_branch;
      wbCtrl     <= d_wb;
      branchCtrl <= d_brc;
      memCtrl    <= d_mem;
      aluOp      <= ALUOP_W'(d_aluop);
      rd         <= instr[11:7];
      rs1        <= instr[19:15];
      rs2        <= instr[24:20];
      illegal    <= d_illegal;
    end
  end

endmodule

// File: doc/pipe_decode_ctrl.md
Name: pipe_decode_ctrl

Overview:
- Registered, pipelined RV32I decode/control stage sitting between IF/ID and EX.
- Decodes a full 32-bit instruction into the team's existing control-word encoding and holds it in an ID/EX control register.
- Adds valid/ready handshaking, load-use hazard bubbles, branch/jump flush, and an optional M-extension with a multi-cycle divide stall.

Parameters:
- ENABLE_M, 0: 1 = decode MUL/DIV/REM (opcode 0110011, f7=0000001); 0 = treat them as illegal.
- MDIV_CYCLES, 8: cycles in_ready stays low after a DIV/DIVU/REM/REMU issues. Legal range 1..255.
- ALUOP_W, 5: aluOp width. Fixed at 5; the parameter exists for EX-side width matching.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- flush  in  1  kill the held op and abort any stall (from EX redirect)
- out_ready  in  1  EX accepts the control word
- out_valid  out  1  control register holds an op
- regWR, memWR, aluS1, aluS2, doJump, doBranch  out  1 each  control bits
- wbCtrl  out  2  writeback select
- branchCtrl  out  3  branch condition
- memCtrl  out  3  memory access type
- aluOp  out  5  ALU operation
- rd, rs1, rs2  out  5 each  register indices, passed through
- illegal  out  1  held op is malformed or unsupported

Behaviour:
- Reset values, one cycle after rst is high: out_valid=0, regWR=0, memWR=0, aluS1=0, aluS2=0, doJump=0, doBranch=0, wbCtrl=2'b11, branchCtrl=3'b011, memCtrl=3'b000, aluOp=5'b01001, rd/rs1/rs2=0, illegal=0, state=IDLE, stall counter=0.
- Base encoding:
  - aluOp = {1'b0, the 4-bit base code}, where the 4-bit base code is:
    - R-type: {f7[5],f3} for f3 000/101; {0,f3} when f7=0; otherwise 1001.
    - I-ALU: same rules, except f3=000 ignores f7.
    - Loads, stores, branches, LUI, AUIPC, JAL, JALR: 0000.
  - wbCtrl: 00 for ALU and upper-immediate ops, 01 for loads, 10 for jumps.
  - memCtrl: LB 000, LH 001, LW 010, LBU 011, LHU 100, SB 101, SH 110, SW 111.
  - aluS1=1 for branches, AUIPC and JAL; aluS2=1 for R-type.
  - Branch: doBranch=1, branchCtrl=f3.
  - JAL/JALR: doJump=1.
- M-extension (ENABLE_M=1): regWR=1, wbCtrl=00, aluS2=1, aluOp={2'b11,f3}.
- Illegal decode: unknown opcode, malformed f3 on load/store, f7 not 0/0100000 on R-type, or M-op with ENABLE_M=0.
  - The op is registered with reset-default controls, illegal=1, out_valid=1.
  - No regWR and no memWR are ever asserted for it.
- Advance condition: advance = !out_valid | out_ready.
- Load-use hazard:
  - Held op is a load (wbCtrl=01), out_valid=1, rd!=0.
  - And rd matches the incoming rs1 (opcodes that read rs1) or rs2 (R-type, store, branch).
- in_ready = advance & !hazard & state==IDLE & !flush.
- On advance, the register loads:
  - the decoded instr if in_valid & in_ready;
  - otherwise a bubble (out_valid=0, controls at reset defaults).
- A hazard inserts exactly one bubble. The next cycle the load has moved on, and the instr is accepted if nothing else blocks it.
- If !advance, all outputs hold.
- State machine:
  - IDLE -> MDIV_WAIT when a DIV/DIVU/REM/REMU is accepted; the counter loads MDIV_CYCLES.
  - MDIV_WAIT: the counter decrements each cycle; in_ready=0; return to IDLE when it reaches 0.
  - MUL* ops never leave IDLE.
- Flush has priority over everything. The next cycle: out_valid=0, controls at defaults, state=IDLE, counter=0. in_ready=0 during the flush cycle.
- rst has priority over flush. rst during MDIV_WAIT returns to IDLE.
- in_ready is combinational from state, out_valid, out_ready, flush and instr. Decode latency is 1 cycle.

Test Plan:
- Reset mid-MDIV_WAIT (rst high 1 cycle) -> next cycle all outputs at reset values, in_ready=1 with out_ready=1.
- ADD x3,x1,x2 (0x002081B3) accepted, out_ready=1 -> next cycle out_valid=1, regWR=1, aluS2=1, wbCtrl=00, aluOp=00000, rd=3.
- LW x5,0(x1), then ADD x6,x5,x4 -> one bubble cycle (in_ready=0, then out_valid=0); ADD issues the cycle after.
- ENABLE_M=1, MDIV_CYCLES=4, DIV issued -> aluOp=11100, in_ready low exactly 4 cycles; flush on cycle 2 -> in_ready high next cycle.
- ENABLE_M=0, MUL -> illegal=1, regWR=0, memWR=0, aluOp=01001.
- out_ready=0 for 3 cycles with BEQ held -> outputs hold stable with doBranch=1, branchCtrl=000; in_ready=0 throughout.
